pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock, clk_in, and its reset, rst_in, SHALL be asynchronous and active-low.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk_in, in, 1: clock.
- rst_in, in, 1: asynchronous active-low reset.
- if_req_stall_in, in, 1: IF fetch still in flight.
- mem_busy_in, in, 1: MEM stage waiting on memory.
- ex_branch_taken_in, in, 1: EX resolved a taken branch or jump.
- ex_is_load_in, in, 1: the instruction in EX is a load.
- ex_rd_addr_in, in, RegAddrBus (5): load destination register.
- id_rs1_use_in, in, 1: ID reads rs1.
- id_rs2_use_in, in, 1: ID reads rs2.
- id_rs1_addr_in, in, 5: ID rs1 address.
- id_rs2_addr_in, in, 5: ID rs2 address.
- stall_out, out, 5: hold per register; bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb.
- bubble_out, out, 5: register loads NOP this cycle; same bit indexing, bit0 always 0.
- redirect_out, out, 1: PC loads the branch target.
- state_out, out, 2: current FSM state.
- stall_cnt_out, out, 16: stall cycle counter.

Function
REQ-003 The block SHALL compute load_use = ex_is_load_in & (ex_rd_addr_in != 0) & ((id_rs1_use_in & id_rs1_addr_in == ex_rd_addr_in) | (id_rs2_use_in & id_rs2_addr_in == ex_rd_addr_in)).
REQ-004 stall_out, bubble_out and redirect_out SHALL be combinational from the registered state and the current inputs, with zero-cycle latency.
REQ-005 The block SHALL apply the first matching rule each cycle:
- (a) mem_busy_in: stall=5'b01111, bubble[4]=1.
- (b) ex_branch_taken_in: redirect=1, bubble[1]=1, bubble[2]=1, stall=0.
- (c) load_use: stall=5'b00011, bubble[2]=1.
- (d) if_req_stall_in: stall=5'b00001, bubble[1]=1.
- (e) none: all outputs 0.
REQ-006 The FSM SHALL have the states RUN=0, MEM_WAIT=1 and DRAIN=2.
REQ-007 RUN SHALL go to MEM_WAIT when mem_busy_in=1; otherwise RUN SHALL go to DRAIN when rule (b) fires with if_req_stall_in=1; otherwise RUN SHALL stay in RUN.
REQ-008 MEM_WAIT SHALL stay while mem_busy_in=1 and SHALL return to RUN on the first cycle mem_busy_in=0; in that exit cycle rules (b)-(e) SHALL apply normally, including entry to DRAIN.
REQ-009 In DRAIN the block SHALL force bubble[1]=1 every cycle, in addition to the rule (a)-(e) outputs, to discard the stale fetch.
REQ-010 DRAIN SHALL exit to RUN after the first cycle in which if_req_stall_in=0, and bubble[1] SHALL still be 1 in that cycle.
REQ-011 mem_busy_in in DRAIN SHALL apply rule (a) while the FSM remains in DRAIN.
REQ-012 A new taken branch in DRAIN SHALL assert redirect_out and SHALL keep the FSM in DRAIN.
REQ-013 stall_cnt_out SHALL increment once per clock edge on which stall_out != 0 and SHALL saturate at 16'hFFFF without wrapping.
REQ-014 ex_rd_addr_in = 0 SHALL never produce a load-use stall.
REQ-015 Whenever any stall bit is set, every lower-index bit SHALL also be set.

Reset
REQ-016 While rst_in=0, the block SHALL set state to RUN and stall_cnt_out to 0, and SHALL drive stall_out=0, bubble_out=0 and redirect_out=0 regardless of the other inputs.
REQ-017 Reset asserted mid-stall or mid-DRAIN SHALL take effect immediately; the first cycle after release SHALL behave as RUN.

Structure
REQ-018 The state encodings, the stall/bubble bit indices and the NOP constants SHALL live in the shared defines file alongside RegAddrBus.
REQ-019 The load-use comparison SHALL be one combinational sub-module, hazard_detect; the FSM, rule priority and counter SHALL stay in pipeline_ctrl.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Load to x5 in EX, ID uses rs2=x5 -> stall=00011, bubble=00100 for one cycle; counter +1.
- Load to x0 in EX, ID uses rs1=x0 -> no stall.
- Taken branch with if_req_stall_in=1 for 3 cycles -> redirect for 1 cycle, state=DRAIN, bubble[1]=1 on all 4 cycles, then RUN.
- mem_busy_in=1 for 4 cycles with branch and load_use also asserted -> stall=01111, bubble=10000 for 4 cycles, no redirect; branch honoured on the exit cycle.
- 65536+ forced stall cycles -> counter holds 16'hFFFF.
- rst_in low during MEM_WAIT -> all outputs 0 immediately, state_out=0, counter 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: register-address width,
// FSM state encodings, stall/bubble bit positions, canned stall patterns
// and the NOP encoding that bubbled pipeline registers load.
package pipeline_ctrl_pkg;

  localparam int RegAddrBus = 5;
  localparam int PIPE_REGS  = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2
  } ctrl_state_e;

  // Bit positions shared by stall_out and bubble_out
  localparam int BIT_PC     = 0;
  localparam int BIT_IF_ID  = 1;
  localparam int BIT_ID_EX  = 2;
  localparam int BIT_EX_MEM = 3;
  localparam int BIT_MEM_WB = 4;

  // Stall patterns are thermometer codes: holding a register means holding
  // everything upstream of it as well.
  localparam logic [PIPE_REGS-1:0] STALL_NONE  = 5'b00000;
  localparam logic [PIPE_REGS-1:0] STALL_FETCH = 5'b00001;
  localparam logic [PIPE_REGS-1:0] STALL_LOAD  = 5'b00011;
  localparam logic [PIPE_REGS-1:0] STALL_MEM   = 5'b01111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use detector.
//   ex_is_load/ex_rd_addr  : load currently in EX and its destination
//   id_rs*_use/id_rs*_addr : source operands read by the instruction in ID
//   load_use               : ID needs a value the EX load has not produced yet
// x0 is hard-wired zero, so a load targeting it never creates a dependency.
import pipeline_ctrl_pkg::*;

module hazard_detect (
  input  logic                  ex_is_load,
  input  logic [RegAddrBus-1:0] ex_rd_addr,
  input  logic                  id_rs1_use,
  input  logic                  id_rs2_use,
  input  logic [RegAddrBus-1:0] id_rs1_addr,
  input  logic [RegAddrBus-1:0] id_rs2_addr,
  output logic                  load_use
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit  = id_rs1_use & (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_rs2_use & (id_rs2_addr == ex_rd_addr);
  assign load_use = ex_is_load & (ex_rd_addr != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall / bubble / redirect generation for a 5-stage pipeline.
//   clk_in, rst_in (async, active low)
//   if_req_stall_in, mem_busy_in, ex_branch_taken_in : hazard sources
//   ex_is_load_in, ex_rd_addr_in, id_rs*_use_in, id_rs*_addr_in : load-use inputs
//   stall_out   : per-register hold (bit0 pc .. bit4 mem_wb)
//   bubble_out  : per-register NOP load, same indexing
//   redirect_out: PC takes the branch target
//   state_out   : RUN / MEM_WAIT / DRAIN
//   stall_cnt_out: saturating count of stalled cycles
// Control outputs are combinational from the registered state and current
// inputs; a single priority chain picks one hazard response per cycle.
import pipeline_ctrl_pkg::*;

module pipeline_ctrl (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  if_req_stall_in,
  input  logic                  mem_busy_in,
  input  logic                  ex_branch_taken_in,
  input  logic                  ex_is_load_in,
  input  logic [RegAddrBus-1:0] ex_rd_addr_in,
  input  logic                  id_rs1_use_in,
  input  logic                  id_rs2_use_in,
  input  logic [RegAddrBus-1:0] id_rs1_addr_in,
  input  logic [RegAddrBus-1:0] id_rs2_addr_in,
  output logic [PIPE_REGS-1:0]  stall_out,
  output logic [PIPE_REGS-1:0]  bubble_out,
  output logic                  redirect_out,
  output logic [1:0]            state_out,
  output logic [15:0]           stall_cnt_out
);

  ctrl_state_e          state_q;
  logic [15:0]          stall_cnt_q;
  logic                 load_use;
  logic [PIPE_REGS-1:0] stall, bubble;
  logic                 redirect;

  hazard_detect u_hazard (
    .ex_is_load  (ex_is_load_in),
    .ex_rd_addr  (ex_rd_addr_in),
    .id_rs1_use  (id_rs1_use_in),
    .id_rs2_use  (id_rs2_use_in),
    .id_rs1_addr (id_rs1_addr_in),
    .id_rs2_addr (id_rs2_addr_in),
    .load_use    (load_use)
  );

  always_comb begin
    stall    = STALL_NONE;
    bubble   = '0;
    redirect = 1'b0;
    if (mem_busy_in) begin
      // Freeze everything up to EX/MEM; MEM/WB gets a NOP so WB does not repeat
      stall              = STALL_MEM;
      bubble[BIT_MEM_WB] = 1'b1;
    end else if (ex_branch_taken_in) begin
      redirect           = 1'b1;
      bubble[BIT_IF_ID]  = 1'b1;
      bubble[BIT_ID_EX]  = 1'b1;
    end else if (load_use) begin
      stall              = STALL_LOAD;
      bubble[BIT_ID_EX]  = 1'b1;
    end else if (if_req_stall_in) begin
      stall              = STALL_FETCH;
      bubble[BIT_IF_ID]  = 1'b1;
    end
    // The fetch that was in flight at redirect time is from the wrong path
    if (state_q == ST_DRAIN) bubble[BIT_IF_ID] = 1'b1;
    // Reset overrides the outputs combinationally, not just at the next edge
    if (!rst_in) begin
      stall    = STALL_NONE;
      bubble   = '0;
      redirect = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      if (stall != STALL_NONE && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;

      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          // MEM_WAIT exit cycle runs the normal rules, so it shares RUN's arcs
          if (mem_busy_in)
            state_q <= ST_MEM_WAIT;
          else if (ex_branch_taken_in && if_req_stall_in)
            state_q <= ST_DRAIN;
          else
            state_q <= ST_RUN;
        end
        ST_DRAIN: begin
          // A new branch restarts the drain; memory stalls just hold it
          if (!mem_busy_in && !ex_branch_taken_in && !if_req_stall_in)
            state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign stall_out     = stall;
  assign bubble_out    = bubble;
  assign redirect_out  = redirect;
  assign state_out     = state_q;
  assign stall_cnt_out = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       if_req_stall_in, mem_busy_in, ex_branch_taken_in, ex_is_load_in;
  logic [4:0] ex_rd_addr_in, id_rs1_addr_in, id_rs2_addr_in;
  logic       id_rs1_use_in, id_rs2_use_in;
  logic [4:0] stall_out, bubble_out;
  logic       redirect_out;
  logic [1:0] state_out;
  logic [15:0] stall_cnt_out;

  typedef struct {
    logic [4:0]  stall;
    logic [4:0]  bubble;
    logic        redirect;
    logic [1:0]  state;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [15:0] cnt_m = 16'd0;

  pipeline_ctrl dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .if_req_stall_in    (if_req_stall_in),
    .mem_busy_in        (mem_busy_in),
    .ex_branch_taken_in (ex_branch_taken_in),
    .ex_is_load_in      (ex_is_load_in),
    .ex_rd_addr_in      (ex_rd_addr_in),
    .id_rs1_use_in      (id_rs1_use_in),
    .id_rs2_use_in      (id_rs2_use_in),
    .id_rs1_addr_in     (id_rs1_addr_in),
    .id_rs2_addr_in     (id_rs2_addr_in),
    .stall_out          (stall_out),
    .bubble_out         (bubble_out),
    .redirect_out       (redirect_out),
    .state_out          (state_out),
    .stall_cnt_out      (stall_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic set_in(input logic ifs, input logic mb, input logic br,
                        input logic ld, input logic [4:0] rd,
                        input logic u1, input logic [4:0] a1,
                        input logic u2, input logic [4:0] a2);
    if_req_stall_in    = ifs;
    mem_busy_in        = mb;
    ex_branch_taken_in = br;
    ex_is_load_in      = ld;
    ex_rd_addr_in      = rd;
    id_rs1_use_in      = u1;
    id_rs1_addr_in     = a1;
    id_rs2_use_in      = u2;
    id_rs2_addr_in     = a2;
  endtask

  // One cycle: drive after the edge, queue the expectation, check mid-cycle.
  task automatic step(input string tag,
                      input logic ifs, input logic mb, input logic br,
                      input logic ld, input logic [4:0] rd,
                      input logic u1, input logic [4:0] a1,
                      input logic u2, input logic [4:0] a2,
                      input logic [4:0] es, input logic [4:0] eb,
                      input logic er, input logic [1:0] est);
    exp_t e;
    @(posedge clk_in);
    #1;
    set_in(ifs, mb, br, ld, rd, u1, a1, u2, a2);
    e.stall = es; e.bubble = eb; e.redirect = er; e.state = est; e.cnt = cnt_m;
    exp_q.push_back(e);
    #3;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".stall"},    {11'd0, stall_out},    {11'd0, e.stall});
      chk({tag, ".bubble"},   {11'd0, bubble_out},   {11'd0, e.bubble});
      chk({tag, ".redirect"}, {15'd0, redirect_out}, {15'd0, e.redirect});
      chk({tag, ".state"},    {14'd0, state_out},    {14'd0, e.state});
      chk({tag, ".cnt"},      stall_cnt_out,         e.cnt);
      chk({tag, ".thermo"},   {11'd0, stall_out & (stall_out + 5'd1)}, 16'd0);
      if (e.stall != 5'd0 && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    end
  endtask

  initial begin
    // Reset with hazards present: outputs must still be quiet
    rst_in = 1'b0;
    set_in(1, 1, 1, 1, 5'd5, 1, 5'd5, 1, 5'd5);
    #2;
    chk("rst.stall",    {11'd0, stall_out},    16'd0);
    chk("rst.bubble",   {11'd0, bubble_out},   16'd0);
    chk("rst.redirect", {15'd0, redirect_out}, 16'd0);
    chk("rst.state",    {14'd0, state_out},    16'd0);
    chk("rst.cnt",      stall_cnt_out,         16'd0);
    set_in(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    //    tag          ifs mb br ld rd    u1 a1    u2 a2    stall     bubble    rd st
    step("idle0",      0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00000, 5'b00000, 0, 2'd0);
    step("lu_x5",      0, 0, 0, 1, 5'd5, 1, 5'd3, 1, 5'd5, 5'b00011, 5'b00100, 0, 2'd0);
    step("after_lu",   0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00000, 5'b00000, 0, 2'd0);
    step("lu_x0",      0, 0, 0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 5'b00000, 5'b00000, 0, 2'd0);
    step("lu_nouse",   0, 0, 0, 1, 5'd7, 0, 5'd7, 0, 5'd7, 5'b00000, 5'b00000, 0, 2'd0);
    step("lu_rs1",     0, 0, 0, 1, 5'd9, 1, 5'd9, 0, 5'd0, 5'b00011, 5'b00100, 0, 2'd0);
    step("fetch",      1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00001, 5'b00010, 0, 2'd0);
    // Taken branch with fetch in flight for 3 cycles -> DRAIN
    step("br0",        1, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00000, 5'b00110, 1, 2'd0);
    step("drain1",     1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00001, 5'b00010, 0, 2'd2);
    step("drain2",     1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00001, 5'b00010, 0, 2'd2);
    step("drain_exit", 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00000, 5'b00010, 0, 2'd2);
    step("run_again",  0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00000, 5'b00000, 0, 2'd0);
    // New branch while draining keeps DRAIN
    step("br1",        1, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00000, 5'b00110, 1, 2'd0);
    step("drain_br",   0, 0, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00000, 5'b00110, 1, 2'd2);
    step("drain_x2",   0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00000, 5'b00010, 0, 2'd2);
    step("run2",       0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00000, 5'b00000, 0, 2'd0);
    // mem_busy outranks branch and load-use for 4 cycles
    step("mem0",       0, 1, 1, 1, 5'd5, 0, 5'd0, 1, 5'd5, 5'b01111, 5'b10000, 0, 2'd0);
    step("mem1",       0, 1, 1, 1, 5'd5, 0, 5'd0, 1, 5'd5, 5'b01111, 5'b10000, 0, 2'd1);
    step("mem2",       0, 1, 1, 1, 5'd5, 0, 5'd0, 1, 5'd5, 5'b01111, 5'b10000, 0, 2'd1);
    step("mem3",       0, 1, 1, 1, 5'd5, 0, 5'd0, 1, 5'd5, 5'b01111, 5'b10000, 0, 2'd1);
    step("mem_exit",   0, 0, 1, 1, 5'd5, 0, 5'd0, 1, 5'd5, 5'b00000, 5'b00110, 1, 2'd1);
    step("run3",       0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00000, 5'b00000, 0, 2'd0);

    // Long forced stall to push the counter into saturation
    @(posedge clk_in);
    #1;
    set_in(1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    repeat (65540) @(posedge clk_in);
    cnt_m = 16'hFFFF;
    step("sat0",       1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00001, 5'b00010, 0, 2'd0);
    step("sat1",       0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00000, 5'b00000, 0, 2'd0);

    // Reset in the middle of MEM_WAIT
    step("mw0",        0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b01111, 5'b10000, 0, 2'd0);
    step("mw1",        0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b01111, 5'b10000, 0, 2'd1);
    @(posedge clk_in);
    #1;
    set_in(1, 1, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0);
    rst_in = 1'b0;
    #1;
    chk("mrst.stall",    {11'd0, stall_out},    16'd0);
    chk("mrst.bubble",   {11'd0, bubble_out},   16'd0);
    chk("mrst.redirect", {15'd0, redirect_out}, 16'd0);
    chk("mrst.state",    {14'd0, state_out},    16'd0);
    chk("mrst.cnt",      stall_cnt_out,         16'd0);
    @(posedge clk_in);
    #1;
    chk("mrst_hold.state", {14'd0, state_out}, 16'd0);
    chk("mrst_hold.cnt",   stall_cnt_out,      16'd0);
    set_in(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    rst_in = 1'b1;
    cnt_m  = 16'd0;
    step("post_rst",   1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00001, 5'b00010, 0, 2'd0);
    step("post_rst1",  0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 5'b00000, 5'b00000, 0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
